// File: rtl/fpu_elastic_rt_buf.sv
// In-order elastic return buffer for FPU result/operand paths.
// A producer reserves a slot with in_en. The data for that slot arrives on d_in
// DATA_LAT cycles later, tagged internally by a delayed copy of the slot index.
// The consumer drains entries strictly in reservation order.
// If the arriving data belongs to the head slot and the consumer is ready, the
// data bypasses storage in the same cycle.
// Handshake: do_ = 1 means d_out is valid AND taken this cycle. A reserve is
// accepted only when a slot is free. pause is advisory back-pressure that keeps
// a compliant producer from reaching the drop case.
module fpu_elastic_rt_buf #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int DATA_LAT    = 2,
   parameter int PAUSE_SLACK = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_en,
   input  logic [WIDTH-1:0]             d_in,
   output logic                         pause,
   input  logic                         flush,
   input  logic                         dout_en,
   output logic [WIDTH-1:0]             d_out,
   output logic                         do_,
   output logic [$clog2(DEPTH+1)-1:0]   occ,
   output logic                         err_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);
   localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
   localparam logic [OW-1:0] SLACK_O = OW'(PAUSE_SLACK);

   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [DEPTH-1:0] rsv;
   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [OW-1:0]    free_cnt;
   logic             reserve;
   logic             arr_v;
   logic [PW-1:0]    arr_idx;
   logic             bypass;
   logic             drain;
   logic             arr_write;

   assign free_cnt = DEPTH_O - occ;
   // Full is decided by occupancy, never by pointer equality.
   assign reserve  = in_en && (occ != DEPTH_O) && !flush;

   generate
      if (DATA_LAT == 0) begin : g_nolat
         // The data arrives together with its request. Equal pointers on an
         // accepted reserve can only mean the buffer is empty, so the new
         // slot is the head slot.
         assign arr_v   = reserve;
         assign arr_idx = tail;
         assign bypass  = arr_v && (arr_idx == head);
      end else begin : g_lat
         logic [DATA_LAT-1:0] pv;
         logic [PW-1:0]       pidx [DATA_LAT];

         assign arr_v   = pv[DATA_LAT-1];
         assign arr_idx = pidx[DATA_LAT-1];
         assign bypass  = arr_v && (arr_idx == head) && rsv[head];

         // Request pipe: carries {valid, slot index} to meet the late data.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               pv <= '0;
               for (int i = 0; i < DATA_LAT; i++) pidx[i] <= '0;
            end else if (flush) begin
               pv <= '0;
            end else begin
               pv[0]   <= reserve;
               pidx[0] <= tail;
               for (int i = 1; i < DATA_LAT; i++) begin
                  pv[i]   <= pv[i-1];
                  pidx[i] <= pidx[i-1];
               end
            end
         end
      end
   endgenerate

   assign drain     = !flush && dout_en && (bypass || vld[head]);
   // The write is skipped only when bypassed data is consumed on the spot.
   assign arr_write = arr_v && !flush && !(bypass && drain);
   assign do_       = drain;
   // An empty head reads as zero, so stale storage never shows up on d_out.
   assign d_out     = bypass ? d_in : (vld[head] ? mem[head] : '0);
   assign pause     = (free_cnt <= SLACK_O) && !(dout_en && (occ != '0));

   // Slot state, pointers and occupancy. A drain at a slot overrides any
   // write or reserve to the same slot in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         rsv  <= '0;
         vld  <= '0;
         occ  <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         rsv  <= '0;
         vld  <= '0;
         occ  <= '0;
      end else begin
         if (reserve) begin
            rsv[tail] <= 1'b1;
            tail      <= tail + PW'(1);
         end
         if (arr_write) begin
            rsv[arr_idx] <= 1'b0;
            vld[arr_idx] <= 1'b1;
         end
         if (drain) begin
            rsv[head] <= 1'b0;
            vld[head] <= 1'b0;
            head      <= head + PW'(1);
         end
         occ <= occ + OW'(reserve) - OW'(drain);
      end
   end

   // Payload storage. No reset is needed because d_out is gated by vld.
   always_ff @(posedge clk) begin
      if (arr_write) mem[arr_idx] <= d_in;
   end

   // Sticky overflow flag. Only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_ovf <= 1'b0;
      end else if (in_en && !flush && (occ == DEPTH_O)) begin
         err_ovf <= 1'b1;
      end
   end

endmodule
